// File: rtl/feature_fetcher.sv
// Walks the new-feature BRAM node by node and delivers each node's vector over valid/ready.
// Define FEAT_FETCH_SATURATE_EN to saturate elements on narrowing; otherwise they are truncated.
module feature_fetcher #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int OUT_FEATURE_WIDTH  = 16,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int NEW_FEATURE_ADDR_W = (NUM_SUBGRAPHS * NUM_FEATURE_OUT > 1) ?
                                     $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT) : 1,
  parameter int NODE_IDX_W         = (NUM_SUBGRAPHS > 1) ? $clog2(NUM_SUBGRAPHS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic [NEW_FEATURE_ADDR_W-1:0]                feat_bram_addrb,
  output logic                                         feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0]                 feat_bram_doutb,
  output logic [NUM_FEATURE_OUT*OUT_FEATURE_WIDTH-1:0] feat_vec,
  output logic                                         feat_vec_vld,
  input  logic                                         feat_vec_rdy,
  output logic [NODE_IDX_W-1:0]                        feat_node_idx,
  output logic                                         fetch_done
);

  localparam int NW  = NEW_FEATURE_WIDTH;
  localparam int OW  = OUT_FEATURE_WIDTH;
  localparam int NFO = NUM_FEATURE_OUT;
  localparam int LAT = BRAM_RD_LATENCY;
  localparam int VW  = NFO * OW;
  localparam int AW  = NEW_FEATURE_ADDR_W;
  localparam int IW  = NODE_IDX_W;
  localparam int CW  = (NFO > 1) ? $clog2(NFO) : 1;

  localparam logic [CW-1:0] LAST_K    = CW'(NFO - 1);
  localparam logic [IW-1:0] LAST_NODE = IW'(NUM_SUBGRAPHS - 1);

`ifdef FEAT_FETCH_SATURATE_EN
  localparam logic [NW-1:0] SAT_MAX = {{(NW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic [NW-1:0] SAT_MIN = {{(NW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  // Exposed for checkers: current FSM state is state_q.
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q;
  logic [CW-1:0]   cap_cnt_q;
  logic [IW-1:0]   node_q;
  logic [AW-1:0]   base_q;
  logic [LAT-1:0]  rd_vld_q;
  logic [VW-1:0]   vec_q;
  logic            rd_tap;
  logic            last_cap;
  logic            accept;
  logic            unused_dout;

  function automatic logic [OW-1:0] narrow(input logic [NW-1:0] w);
`ifdef FEAT_FETCH_SATURATE_EN
    if ($signed(w) > $signed(SAT_MAX))      return SAT_MAX[OW-1:0];
    else if ($signed(w) < $signed(SAT_MIN)) return SAT_MIN[OW-1:0];
    else                                    return w[OW-1:0];
`else
    return w[OW-1:0];
`endif
  endfunction

  assign unused_dout = ^feat_bram_doutb;
  assign rd_tap      = rd_vld_q[LAT-1];
  assign last_cap    = rd_tap && (cap_cnt_q == LAST_K);
  assign accept      = (state_q == HOLD) && feat_vec_rdy;

  // Handshake: a vector transfers in any cycle where feat_vec_vld && feat_vec_rdy;
  // once raised, feat_vec_vld, feat_vec and feat_node_idx stay put until that transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (rd_cnt_q == LAST_K) state_d = WAIT;
      WAIT:  if (last_cap) state_d = HOLD;
      HOLD:  if (accept) state_d = (node_q == LAST_NODE) ? DONE : FETCH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      node_q    <= '0;
      base_q    <= '0;
      rd_vld_q  <= '0;
      vec_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= (rd_vld_q << 1) | LAT'(feat_bram_enb);
      if (state_q == FETCH)
        rd_cnt_q <= (rd_cnt_q == LAST_K) ? '0 : rd_cnt_q + 1'b1;
      // Address base+k holds element NFO-1-k, so shifting left lands the first word on top.
      if (rd_tap) begin
        cap_cnt_q <= (cap_cnt_q == LAST_K) ? '0 : cap_cnt_q + 1'b1;
        vec_q     <= (vec_q << OW) | VW'(narrow(feat_bram_doutb));
      end
      if (state_q == IDLE) begin
        node_q <= '0;
        base_q <= '0;
      end else if (accept && (node_q != LAST_NODE)) begin
        node_q <= node_q + 1'b1;
        base_q <= base_q + AW'(NFO);
      end
    end
  end

  assign feat_bram_enb   = (state_q == FETCH);
  assign feat_bram_addrb = base_q + AW'(rd_cnt_q);
  assign feat_vec        = vec_q;
  assign feat_vec_vld    = (state_q == HOLD);
  assign feat_node_idx   = node_q;
  assign fetch_done      = (state_q == DONE);

endmodule
